// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit -- iterative radix-2 multiply/divide execution unit.
//
// One operation at a time. An accepted start latches the operands and runs
// WIDTH shift-add (multiply) or restoring-divide iterations on operand
// magnitudes. Signs are applied when the last iteration writes the result
// registers. A divide by zero bypasses the iterations entirely.
//
// Ports:
//   clk          sole clock, rising edge
//   R            synchronous active-high reset (overrides start/flush)
//   start        request a new operation (sampled only in IDLE)
//   op           00 UMUL, 01 SMUL, 10 UDIV, 11 SDIV
//   a, b         multiplicand/dividend, multiplier/divisor
//   cc_req       request a condition-code update at completion
//   flush        abort the in-flight operation; beats start in IDLE
//   busy         state is not IDLE
//   stall        (IDLE & start & ~flush) | RUN, pipeline freeze
//   done         one-cycle completion pulse (suppressed by flush)
//   result_lo    product low half / quotient (registered, held)
//   result_hi    product high half / remainder (registered, held)
//   div_by_zero  completed divide had b == 0
//   n, z, v, c   condition codes for the completed operation
//   flags_we     PSR flag write enable
//
// Handshake: start is a request with no backpressure signal of its own; it is
// consumed on the rising edge where state is IDLE, start=1 and flush=0. Any
// start seen while busy is dropped. done is a single-cycle pulse that the
// consumer must sample in that cycle; results stay valid afterwards.
//
// Configuration macro: MULDIV_CC_EN enables the condition-code outputs.
// Without it n, z, v, c and flags_we are tied to 0 and cc_req is ignored.

module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             R,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cc_req,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic             n,
  output logic             z,
  output logic             v,
  output logic             c,
  output logic             flags_we
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;   // partial product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0] dvs;      // multiplicand or divisor magnitude
  logic             is_div_q;
  logic             neg_q;    // negate product or quotient at the end
  logic             rneg_q;   // negate remainder at the end
  logic             cc_q;
  logic             ovf_q;    // SDIV most-negative / -1 case

  logic             accept;
  logic             div_zero_in;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] neg_prod;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  assign accept      = (state == S_IDLE) && start && !flush;
  assign div_zero_in = op[1] && (b == '0);
  assign a_mag       = (op[0] && a[WIDTH-1]) ? -a : a;
  assign b_mag       = (op[0] && b[WIDTH-1]) ? -b : b;

  // One radix-2 step for each algorithm; the latched op picks one.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvs} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    // The partial remainder is always below the divisor, so bit WIDTH of the
    // difference is a clean borrow flag.
    div_diff  = div_shift - {1'b0, dvs};
    if (is_div_q) begin
      step_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied on the final iteration. The SDIV overflow case falls
  // out naturally: the magnitude quotient is 2^(WIDTH-1) and is not negated.
  always_comb begin
    neg_prod = -{step_hi, step_lo};
    if (is_div_q) begin
      fin_lo = neg_q  ? -step_lo : step_lo;
      fin_hi = rneg_q ? -step_hi : step_hi;
    end else begin
      fin_lo = neg_q ? neg_prod[WIDTH-1:0]       : step_lo;
      fin_hi = neg_q ? neg_prod[2*WIDTH-1:WIDTH] : step_hi;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = div_zero_in ? S_DONE : S_RUN;
      S_RUN: begin
        if (flush)                  state_next = S_IDLE;
        else if (cnt == CW'(1))     state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state       <= S_IDLE;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      dvs         <= '0;
      is_div_q    <= 1'b0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      cc_q        <= 1'b0;
      ovf_q       <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (accept) begin
            is_div_q <= op[1];
            neg_q    <= op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_q   <= op[0] && a[WIDTH-1];
            cc_q     <= cc_req;
            ovf_q    <= (op == 2'b11) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
            acc_hi   <= '0;
            acc_lo   <= a_mag;
            dvs      <= b_mag;
            if (div_zero_in) begin
              cnt         <= '0;
              result_lo   <= '1;
              result_hi   <= a;
              div_by_zero <= 1'b1;
            end else begin
              cnt <= CW'(WIDTH);
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            cnt <= '0;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              result_lo   <= fin_lo;
              result_hi   <= fin_hi;
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign stall = accept || (state == S_RUN);
  assign done  = (state == S_DONE) && !flush;

`ifdef MULDIV_CC_EN
  assign n        = (state == S_DONE) && result_lo[WIDTH-1];
  assign z        = (state == S_DONE) && (result_lo == '0);
  assign v        = (state == S_DONE) && ovf_q;
  assign c        = 1'b0;
  assign flags_we = done && cc_q;
`else
  logic unused_cc;
  assign unused_cc = ^{cc_q, ovf_q};
  assign n        = 1'b0;
  assign z        = 1'b0;
  assign v        = 1'b0;
  assign c        = 1'b0;
  assign flags_we = 1'b0;
`endif

endmodule
